if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/polirv_pkg.sv | 15 +
 rtl/if_fifo.sv | 50 +++++
 rtl/if_prefetch.sv | 130 +++++++++++++
 3 files changed

// File: rtl/polirv_pkg.sv
// Shared core constants and types.
// Fetch-side widths, PC step and prefetch FSM states.
package polirv_pkg;

  localparam int INST_W   = 32;
  localparam int PC_INC   = 4;
  localparam int RESET_PC = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } pf_state_e;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush.
// Head word reads as zero whenever the FIFO is empty.
module if_fifo #(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [width-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [width-1:0]         data_o,
  output logic [$clog2(depth):0]   count_o
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: one outstanding fetch feeding a small buffer.
// Redirects flush the buffer; an in-flight response is drained and dropped.
module if_prefetch
  import polirv_pkg::*;
#(
  parameter int i_addr_bits = 6,
  parameter int depth       = 4,
  parameter int reset_pc    = RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   i_mem_req,
  output logic [i_addr_bits-1:0] i_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [INST_W-1:0]      i_mem_data,
  input  logic                   redirect,
  input  logic [i_addr_bits-1:0] redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INST_W-1:0]      inst_data,
  output logic [i_addr_bits-1:0] inst_pc
);

  localparam int AW = i_addr_bits;
  localparam int CW = $clog2(depth) + 1;
  localparam int OW = CW + 1;
  localparam int EW = INST_W + AW;
  localparam logic [AW-1:0] PC0 = AW'(reset_pc);
  localparam logic [AW-1:0] INC = AW'(PC_INC);

  pf_state_e     state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] tgt_q, tgt_d;

  logic          ack_ok, push, pop, space;
  logic [CW-1:0] count;
  logic [OW-1:0] occ_nxt;
  logic [EW-1:0] head;

  assign ack_ok  = req_q & i_mem_ack;
  assign push    = ack_ok & (state_q == FETCH) & ~redirect;
  assign pop     = inst_valid & inst_ready & ~redirect;
  assign occ_nxt = redirect ? '0
                 : {1'b0, count} + OW'(push) - OW'(pop);
  assign space   = occ_nxt < OW'(depth);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      addr_q  <= PC0;
      tgt_q   <= PC0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (req_q & ~i_mem_ack) ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        FETCH:   if (ack_ok & ~space) state_d = HOLD;
        HOLD:    if (space) state_d = FETCH;
        DRAIN:   if (ack_ok) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // Request line and address; req_q low in FETCH only right after reset.
  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    tgt_d  = tgt_q;
    if (redirect) begin
      if (req_q & ~i_mem_ack) begin
        tgt_d = redirect_pc;
      end else begin
        addr_d = redirect_pc;
        req_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack_ok) begin
            addr_d = addr_q + INC;
            req_d  = space;
          end else if (!req_q) begin
            req_d = space;
          end
        end
        HOLD:  req_d = space;
        DRAIN: begin
          if (ack_ok) begin
            addr_d = tgt_q;
            req_d  = 1'b1;
          end
        end
        default: req_d = 1'b0;
      endcase
    end
  end

  if_fifo #(
    .width (EW),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  ({i_mem_data, addr_q}),
    .pop_i   (pop),
    .valid_o (inst_valid),
    .data_o  (head),
    .count_o (count)
  );

  assign i_mem_req  = req_q;
  assign i_mem_addr = addr_q;
  assign inst_data  = head[EW-1:AW];
  assign inst_pc    = head[AW-1:0];

endmodule
